bit_count_engine: RTL and testbench

//  Multi-mode bit-statistics engine: one shift per clock, with a valid/ready handshake on both sides.

---
 rtl/bit_count_pkg.sv | 17 +
 rtl/bit_count_datapath.sv | 62 ++++++
 rtl/bit_count_engine.sv | 81 ++++++++
 tb/tb_bit_count_engine.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bit_count_pkg.sv
// Shared types for the bit-statistics engine: operating modes and control FSM states.
package bit_count_pkg;

  typedef enum logic [1:0] {
    ONES   = 2'b00,
    ZEROS  = 2'b01,
    CTZ    = 2'b10,
    PARITY = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bit_count_datapath.sv
// Shift register, counter and result mux for the bit-statistics engine.
// Sequenced by load/shift/capture strobes from the control FSM.
module bit_count_datapath
  import bit_count_pkg::*;
#(
  parameter int unsigned W = 30,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic          capture,
  input  logic [W-1:0]  in_data,
  input  mode_t         in_mode,
  output logic          term,
  output logic [CW-1:0] out_data
);

  logic [W-1:0]  sreg_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] result;
  logic [CW-1:0] out_data_q;
  mode_t         mode_q;

  // CTZ stops at the first set bit; every mode stops once the word is exhausted.
  assign term = (sreg_q == '0) || ((mode_q == CTZ) && sreg_q[0]);

  always_comb begin
    result = count_q;
    unique case (mode_q)
      ONES, ZEROS: result = count_q;
      PARITY:      result = CW'(count_q[0]);
      CTZ:         result = (sreg_q != '0) ? count_q : CW'(W);
      default:     result = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg_q     <= '0;
      count_q    <= '0;
      mode_q     <= ONES;
      out_data_q <= '0;
    end else begin
      if (load) begin
        sreg_q  <= (in_mode == ZEROS) ? ~in_data : in_data;
        mode_q  <= in_mode;
        count_q <= '0;
      end else if (shift) begin
        sreg_q  <= sreg_q >> 1;
        count_q <= count_q + ((mode_q == CTZ) ? CW'(1) : CW'(sreg_q[0]));
      end
      if (capture) begin
        out_data_q <= result;
      end
    end
  end

  assign out_data = out_data_q;

endmodule

// File: rtl/bit_count_engine.sv
// Multi-mode bit-statistics engine (ones, zeros, trailing zeros, parity), one shift per clock,
// with valid/ready handshakes on input and output.
module bit_count_engine
  import bit_count_pkg::*;
#(
  parameter int unsigned W = 30,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic          busy
);

  state_t state_q, state_d;
  logic   load, shift, capture, term;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    capture   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (term) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bit_count_datapath #(
    .W (W)
  ) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .capture  (capture),
    .in_data  (in_data),
    .in_mode  (mode_t'(in_mode)),
    .term     (term),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_bit_count_engine.sv
// Directed self-checking bench for bit_count_engine with hand-computed results and latencies.
module tb_bit_count_engine;

  localparam int unsigned W  = 30;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic          busy;

  int errors = 0;
  int checks = 0;

  bit_count_engine #(
    .W (W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept edge with in_valid already driven; in_valid drops right after it.
  task automatic accept(input string tag);
    tick();
    in_valid = 1'b0;
    check({tag, ".busy_after_accept"}, int'(busy), 1);
    check({tag, ".in_ready_after_accept"}, int'(in_ready), 0);
  endtask

  task automatic start(input string tag, input logic [1:0] mode, input logic [W-1:0] data);
    in_mode  = mode;
    in_data  = data;
    in_valid = 1'b1;
    accept(tag);
  endtask

  // Counts edges since the accept edge until out_valid; busy must stay high while computing.
  task automatic wait_result(input string tag, input int exp_data, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < int'(W) + 5) begin
      if (busy !== 1'b1) check({tag, ".busy_in_calc"}, int'(busy), 1);
      tick();
      lat++;
    end
    check({tag, ".out_valid"}, int'(out_valid), 1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".data"}, int'(out_data), exp_data);
    check({tag, ".busy_done"}, int'(busy), 1);
    check({tag, ".in_ready_done"}, int'(in_ready), 0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, int'(out_valid), 0);
    check({tag, ".idle_in_ready"}, int'(in_ready), 1);
    check({tag, ".idle_busy"}, int'(busy), 0);
  endtask

  task automatic run(input string tag, input logic [1:0] mode, input logic [W-1:0] data,
                     input int exp_data, input int exp_lat);
    start(tag, mode, data);
    wait_result(tag, exp_data, exp_lat);
    release_result(tag);
  endtask

  initial begin
    int seen_valid;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset.in_ready", int'(in_ready), 1);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.out_data", int'(out_data), 0);
    reset = 1'b0;

    // First cycle after reset release is accepted normally.
    run("ones_2", 2'b00, 30'h0000_0002, 1, 3);
    run("ones_0", 2'b00, 30'h0000_0000, 0, 1);
    run("ones_all", 2'b00, 30'h3FFF_FFFF, 30, 31);
    run("zeros", 2'b01, 30'h3FFF_FFF0, 4, 5);
    run("ctz_100", 2'b10, 30'h0000_0100, 8, 9);
    run("ctz_0", 2'b10, 30'h0000_0000, 30, 1);
    run("par_7", 2'b11, 30'h0000_0007, 1, 4);
    run("par_3", 2'b11, 30'h0000_0003, 0, 3);

    // Back-pressure; a new offer during DONE must wait for the following IDLE cycle.
    start("bp", 2'b00, 30'h0000_0007);
    wait_result("bp", 3, 4);
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = 30'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold_valid", int'(out_valid), 1);
      check("bp.hold_data", int'(out_data), 3);
      check("bp.hold_in_ready", int'(in_ready), 0);
      check("bp.hold_busy", int'(busy), 1);
    end
    release_result("bp");
    accept("bp_next");
    wait_result("bp_next", 1, 2);
    release_result("bp_next");

    // Reset mid-CALC discards the run and clears the held result.
    start("rst", 2'b00, 30'h2000_0000);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst.in_ready", int'(in_ready), 1);
    check("rst.busy", int'(busy), 0);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.out_data", int'(out_data), 0);
    tick();
    reset = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < int'(W) + 5; i++) begin
      tick();
      if (out_valid) seen_valid = 1;
      if (busy) seen_valid = 1;
    end
    check("rst.no_out_valid", seen_valid, 0);
    run("after_rst", 2'b00, 30'h0000_0005, 2, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
